// File: rtl/data_bus_unit.sv
// data_bus_unit: address decode between a word-addressed data RAM and a small
// MMIO window holding GPIO output, synchronised GPIO input and a compare timer.
// Reads are combinational; every write lands at the rising clock edge.
module data_bus_unit #(
  parameter int WIDTH         = 32,
  parameter int RAM_ADDR_BITS = 10,
  parameter int GPIO_WIDTH    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      ram_address,
  input  logic [WIDTH-1:0]      ram_w_data,
  input  logic                  read_write_ram_en,
  output logic [WIDTH-1:0]      ram_r_data,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;

  localparam logic [2:0] REG_GPIO_OUT = 3'd0;
  localparam logic [2:0] REG_GPIO_IN  = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_CMP      = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  // Address decode: top nibble picks the region, RAM aliases through its region
  logic                     selRam;
  logic                     selMmio;
  logic [2:0]               regSel;
  logic [RAM_ADDR_BITS-1:0] wordIdx;
  logic                     unusedAddr;

  assign selRam     = (ram_address[WIDTH-1:WIDTH-4] == 4'h0);
  assign selMmio    = (ram_address[WIDTH-1:WIDTH-4] == 4'h1);
  assign regSel     = ram_address[4:2];
  assign wordIdx    = ram_address[RAM_ADDR_BITS+1:2];
  assign unusedAddr = ^{ram_address[WIDTH-5:RAM_ADDR_BITS+2], ram_address[1:0]};

  // Write strobes; a write presented during reset must never reach the RAM
  logic ramWe;
  logic mmioWe;
  logic wrGpio;
  logic wrCount;
  logic wrCmp;
  logic wrCtrl;
  logic wrStatus;

  assign ramWe    = read_write_ram_en && selRam && !reset;
  assign mmioWe   = read_write_ram_en && selMmio;
  assign wrGpio   = mmioWe && (regSel == REG_GPIO_OUT);
  assign wrCount  = mmioWe && (regSel == REG_COUNT);
  assign wrCmp    = mmioWe && (regSel == REG_CMP);
  assign wrCtrl   = mmioWe && (regSel == REG_CTRL);
  assign wrStatus = mmioWe && (regSel == REG_STATUS);

  // Data RAM storage; contents deliberately survive reset
  logic [WIDTH-1:0] ramMem [RAM_DEPTH];

  // RAM write port
  always_ff @(posedge clock) begin
    if (ramWe) begin
      ramMem[wordIdx] <= ram_w_data;
    end
  end

  // MMIO state
  logic [GPIO_WIDTH-1:0] gpioOut_q, gpioOut_d;
  logic [GPIO_WIDTH-1:0] gpioSync1_q;
  logic [GPIO_WIDTH-1:0] gpioSync2_q;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      cmp_q, cmp_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  matchFlag_q, matchFlag_d;

  logic timerEnable;
  logic timerAutoClear;
  logic timerIrqEn;
  logic timerMatch;

  assign timerEnable    = ctrl_q[0];
  assign timerAutoClear = ctrl_q[1];
  assign timerIrqEn     = ctrl_q[2];
  assign timerMatch     = timerEnable && (count_q == cmp_q);

  // Next-state for GPIO and timer: software load beats auto-clear beats counting, and a match beats W1C
  always_comb begin
    gpioOut_d   = gpioOut_q;
    count_d     = count_q;
    cmp_d       = cmp_q;
    ctrl_d      = ctrl_q;
    matchFlag_d = matchFlag_q;

    if (wrGpio) begin
      gpioOut_d = ram_w_data[GPIO_WIDTH-1:0];
    end

    if (wrCmp) begin
      cmp_d = ram_w_data;
    end

    if (wrCtrl) begin
      ctrl_d = ram_w_data[2:0];
    end

    if (wrCount) begin
      count_d = ram_w_data;
    end else if (timerMatch && timerAutoClear) begin
      count_d = '0;
    end else if (timerEnable) begin
      count_d = count_q + WIDTH'(1);
    end

    if (timerMatch) begin
      matchFlag_d = 1'b1;
    end else if (wrStatus && ram_w_data[0]) begin
      matchFlag_d = 1'b0;
    end
  end

  // MMIO registers and the two-flop input synchroniser, all with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      gpioOut_q   <= '0;
      gpioSync1_q <= '0;
      gpioSync2_q <= '0;
      count_q     <= '0;
      cmp_q       <= '1;
      ctrl_q      <= '0;
      matchFlag_q <= 1'b0;
    end else begin
      gpioOut_q   <= gpioOut_d;
      gpioSync1_q <= gpio_in;
      gpioSync2_q <= gpioSync1_q;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      ctrl_q      <= ctrl_d;
      matchFlag_q <= matchFlag_d;
    end
  end

  assign gpio_out  = gpioOut_q;
  assign timer_irq = matchFlag_q && timerIrqEn;

  // Combinational read mux; reads have no side effects on any register
  always_comb begin
    ram_r_data = '0;
    if (selRam) begin
      ram_r_data = ramMem[wordIdx];
    end else if (selMmio) begin
      case (regSel)
        REG_GPIO_OUT: ram_r_data[GPIO_WIDTH-1:0] = gpioOut_q;
        REG_GPIO_IN:  ram_r_data[GPIO_WIDTH-1:0] = gpioSync2_q;
        REG_COUNT:    ram_r_data = count_q;
        REG_CMP:      ram_r_data = cmp_q;
        REG_CTRL:     ram_r_data[2:0] = ctrl_q;
        REG_STATUS:   ram_r_data[0] = matchFlag_q;
        default:      ram_r_data = '0;
      endcase
    end
  end

endmodule

// File: doc/data_bus_unit.md
Name: data_bus_unit

Overview:
- Downstream of the pipelined data path's memory stage; consumes its `ram_address`, `ram_w_data` and `read_write_ram_en`, and returns `ram_r_data`.
- Decodes the address into two regions: a word-addressed data RAM and a small MMIO peripheral window (GPIO output, synchronised GPIO input, and a 32-bit compare timer with interrupt).
- Reads are combinational, because the data path registers `ram_r_data` into MEM/WB at the next edge. Writes take effect at the clock edge.

Parameters:
- WIDTH, 32, data and address width.
- RAM_ADDR_BITS, 10, log2 of RAM depth in words (default 1024 words = 4 KiB).
- GPIO_WIDTH, 8, width of `gpio_out` and `gpio_in` (1..32).

Ports:
- clock  in  1  global clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ram_address  in  WIDTH  byte address from the memory stage; bits [1:0] ignored.
- ram_w_data  in  WIDTH  store data.
- read_write_ram_en  in  1  1 = write this cycle; 0 = read only.
- ram_r_data  out  WIDTH  combinational read data for `ram_address`.
- gpio_in  in  GPIO_WIDTH  asynchronous external inputs.
- gpio_out  out  GPIO_WIDTH  registered GPIO output.
- timer_irq  out  1  registered-level interrupt: match_flag AND irq_en.

Behaviour:
- Region decode on ram_address[31:28]:
  - 4'h0: RAM. Word index = ram_address[RAM_ADDR_BITS+1:2]; higher bits ignored, so the RAM aliases through the region.
  - 4'h1: MMIO. Register select = ram_address[4:2]; all other bits ignored.
  - Any other value: reads return 0, writes are ignored.
- RAM:
  - Write at the clock edge when read_write_ram_en = 1.
  - Read is asynchronous, so a write to address A followed by a read of A on the next cycle returns the new data.
  - A same-cycle read of the address being written returns the old data.
  - Contents are NOT affected by reset.
- MMIO map (offset from 0x1000_0000); unused bits read 0, writes to read-only registers are ignored:
  - 0x00 GPIO_OUT, R/W, low GPIO_WIDTH bits. Drives `gpio_out`; reset 0.
  - 0x04 GPIO_IN, R. Output of a 2-flop synchroniser on `gpio_in`; both flops reset to 0. A change on `gpio_in` is visible after the 2nd rising edge.
  - 0x08 TIMER_COUNT, R/W, reset 0.
  - 0x0C TIMER_CMP, R/W, reset 0xFFFF_FFFF.
  - 0x10 TIMER_CTRL, R/W, reset 0. bit0 = enable, bit1 = auto_clear, bit2 = irq_en.
  - 0x14 TIMER_STATUS. bit0 = match_flag, reset 0. Write 1 to bit0 clears it; writing 0 has no effect.
  - 0x18, 0x1C: read 0, writes ignored.
- Timer, evaluated every edge:
  - match = enable AND (count == cmp).
  - Count, in priority order:
    1. Software write to TIMER_COUNT loads ram_w_data.
    2. Else if match and auto_clear, count <= 0.
    3. Else if enable, count <= count + 1, modulo 2^32 (0xFFFF_FFFF wraps to 0 silently).
    4. Else hold.
  - Flag: if match, match_flag <= 1 (set wins over a same-cycle W1C). Else if a W1C write, match_flag <= 0.
  - timer_irq is combinational from registered state: match_flag & irq_en. It is high on the edge after the match cycle.
- Reads have no side effects. There is no read strobe, so nothing may clear on read.
- Reset mid-operation: all MMIO registers, the synchroniser flops, `gpio_out` and `timer_irq` return to reset values on the reset edge. RAM is preserved. A write presented in the reset cycle is dropped, for MMIO and RAM alike.
- Reset output values: gpio_out = 0, timer_irq = 0. ram_r_data is combinational: it reflects RAM contents, or 0xFFFF_FFFF when reading CMP.

Test Plan:
1. RAM round-trip and aliasing:
   - Write 0xDEADBEEF to 0x0000_0040. Next cycle, reads of 0x40, 0x42 and 0x0000_1040 all return 0xDEADBEEF; read of 0x44 is unchanged.
   - Write and read at 0x2000_0000: read 0, RAM untouched.
2. GPIO:
   - Write 0x0000_01A5 to 0x1000_0000 → gpio_out = 0xA5 after the edge; read returns 0x0000_00A5.
   - Set gpio_in = 0x3C → GPIO_IN reads 0 after 1 edge, 0x3C after 2 edges.
3. Timer match and IRQ:
   - Program CMP = 5, COUNT = 0, CTRL = 0b101.
   - COUNT reads 5 after 5 enabled edges. Next edge: match_flag = 1, timer_irq = 1, COUNT = 6.
   - Write 1 to STATUS → flag and irq clear next edge; write 0 does not clear.
4. Auto-clear and wrap:
   - CTRL = 0b011, CMP = 3 → COUNT sequence 0, 1, 2, 3, 0, 1, …; flag sets on the first match.
   - CTRL = 0b001, COUNT = 0xFFFF_FFFE → sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
5. Simultaneous events:
   - W1C to STATUS in the same cycle as a match → flag stays 1.
   - Write COUNT = 0x100 in the same cycle an auto-clear match would zero it → COUNT = 0x100.
6. Reset mid-operation:
   - Assert reset for 1 cycle while the timer runs with flag = 1 and gpio_out = 0xFF → COUNT = 0, CMP = 0xFFFF_FFFF, CTRL = 0, flag = 0, timer_irq = 0, gpio_out = 0.
   - A previously written RAM word still reads back intact; a RAM write issued during the reset cycle is dropped.
